// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - multi-cycle multiply/divide engine owning the HI/LO register pair
module ex_muldiv_unit #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 flush,
    output logic                 busy,
    output logic                 stall,
    output logic                 done,
    output logic                 div_by_zero,
    output logic [WIDTH-1:0]     hi,
    output logic [WIDTH-1:0]     lo,
    output logic [2*WIDTH-1:0]   hilo_fwd
);

    localparam int CW = $clog2(WIDTH + MUL_LATENCY + 2) + 1;
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LATENCY);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {IDLE, MUL, DIV} stateT;

    stateT              state, nextState;
    logic [CW-1:0]      counter, nextCounter;

    logic               isMulOp, isDivOp, isMoveOp, opSigned, accept;

    // Captured operation context
    logic [2*WIDTH-1:0] prodReg;
    logic [WIDTH-1:0]   remReg, quoReg, divisorMag, divDividend;
    logic               divZero, divNegQ, divNegR;

    // Datapath intermediates
    logic [2*WIDTH-1:0] mulA, mulB;
    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   subVal;
    logic               stepOk;
    logic [WIDTH-1:0]   newHi, newLo;

    assign isMulOp  = (op == OP_MULT) || (op == OP_MULTU);
    assign isDivOp  = (op == OP_DIV)  || (op == OP_DIVU);
    assign isMoveOp = (op == OP_MTHI) || (op == OP_MTLO);
    assign opSigned = ~op[0];
    assign accept   = rst && start && !flush && (state == IDLE);

    // Sign- or zero-extend multiplier operands so one 2W-bit product covers both forms
    assign mulA = {{WIDTH{opSigned & a[WIDTH-1]}}, a};
    assign mulB = {{WIDTH{opSigned & b[WIDTH-1]}}, b};

    // One restoring step: shift in next dividend bit, subtract divisor if it fits
    assign shifted = {remReg, quoReg[WIDTH-1]};
    assign stepOk  = (shifted >= {1'b0, divisorMag});
    assign subVal  = shifted[WIDTH-1:0] - divisorMag;

    // State register and step counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            counter <= '0;
        end else begin
            state   <= nextState;
            counter <= nextCounter;
        end
    end

    // Next-state, completion pulse and handshake outputs
    always_comb begin
        nextState   = state;
        nextCounter = counter;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (accept && isMulOp) begin
                    nextState   = MUL;
                    nextCounter = CW'(1);
                end else if (accept && isDivOp) begin
                    nextState   = DIV;
                    nextCounter = CW'(1);
                end else if (accept && isMoveOp) begin
                    done = 1'b1;
                end
            end
            MUL: begin
                if (flush) begin
                    nextState   = IDLE;
                    nextCounter = '0;
                end else if (counter == MUL_LAST) begin
                    done        = 1'b1;
                    nextState   = IDLE;
                    nextCounter = '0;
                end else begin
                    nextCounter = counter + CW'(1);
                end
            end
            DIV: begin
                if (flush) begin
                    nextState   = IDLE;
                    nextCounter = '0;
                end else if (counter == DIV_LAST) begin
                    done        = 1'b1;
                    nextState   = IDLE;
                    nextCounter = '0;
                end else begin
                    nextCounter = counter + CW'(1);
                end
            end
            default: begin
                nextState   = IDLE;
                nextCounter = '0;
            end
        endcase
    end

    assign busy        = (state != IDLE);
    assign stall       = start && !done && !flush && (busy || isMulOp || isDivOp);
    assign div_by_zero = done && (state == DIV) && divZero;

    // Value HI/LO will take at the end of a done cycle; otherwise the current pair
    always_comb begin
        newHi = hi;
        newLo = lo;
        if (done) begin
            case (state)
                IDLE: begin
                    if (op == OP_MTHI) newHi = a;
                    else               newLo = a;
                end
                MUL: begin
                    newHi = prodReg[2*WIDTH-1:WIDTH];
                    newLo = prodReg[WIDTH-1:0];
                end
                DIV: begin
                    if (divZero) begin
                        newHi = divDividend;
                        newLo = '1;
                    end else begin
                        newLo = divNegQ ? -quoReg : quoReg;
                        newHi = divNegR ? -remReg : remReg;
                    end
                end
                default: begin
                    newHi = hi;
                    newLo = lo;
                end
            endcase
        end
    end

    assign hilo_fwd = {newHi, newLo};

    // HI/LO write-back, operand capture and divide iteration
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi          <= '0;
            lo          <= '0;
            prodReg     <= '0;
            remReg      <= '0;
            quoReg      <= '0;
            divisorMag  <= '0;
            divDividend <= '0;
            divZero     <= 1'b0;
            divNegQ     <= 1'b0;
            divNegR     <= 1'b0;
        end else begin
            if (done) begin
                hi <= newHi;
                lo <= newLo;
            end
            if (accept && isMulOp) begin
                prodReg <= mulA * mulB;
            end else if (accept && isDivOp) begin
                divDividend <= a;
                divZero     <= (b == '0);
                divisorMag  <= (opSigned && b[WIDTH-1]) ? -b : b;
                quoReg      <= (opSigned && a[WIDTH-1]) ? -a : a;
                remReg      <= '0;
                divNegQ     <= opSigned && (a[WIDTH-1] ^ b[WIDTH-1]);
                divNegR     <= opSigned && a[WIDTH-1];
            end else if (state == DIV && !flush && counter != DIV_LAST) begin
                remReg <= stepOk ? subVal : shifted[WIDTH-1:0];
                quoReg <= {quoReg[WIDTH-2:0], stepOk};
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, flush;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, stall, done, divByZero;
    logic [31:0] hi, lo;
    logic [63:0] hiloFwd;

    logic        start16, flush16;
    logic [2:0]  op16;
    logic [15:0] a16, b16;
    logic        busy16, stall16, done16, divByZero16;
    logic [15:0] hi16, lo16;
    logic [31:0] hiloFwd16;

    int nTests = 0;
    int nFail  = 0;

    int          dc, sc, cnt;
    logic [63:0] fw;
    logic        dz;
    logic [31:0] hd, ld;

    always #5 clk = ~clk;

    ex_muldiv_unit #(.WIDTH(32), .MUL_LATENCY(3)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .busy(busy), .stall(stall), .done(done), .div_by_zero(divByZero),
        .hi(hi), .lo(lo), .hilo_fwd(hiloFwd)
    );

    ex_muldiv_unit #(.WIDTH(16), .MUL_LATENCY(1)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .op(op16), .a(a16), .b(b16), .flush(flush16),
        .busy(busy16), .stall(stall16), .done(done16), .div_by_zero(divByZero16),
        .hi(hi16), .lo(lo16), .hilo_fwd(hiloFwd16)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that ends the done cycle
    task automatic runOp(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int doneCyc, output int stallCnt, output logic [63:0] fwd,
                         output logic dzOut, output logic [31:0] hiAt, output logic [31:0] loAt);
        start = 1'b1; op = o; a = x; b = y;
        doneCyc = -1; stallCnt = 0; fwd = '0; dzOut = 1'b0; hiAt = '0; loAt = '0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (stall) stallCnt++;
            if (done) begin
                doneCyc = c; fwd = hiloFwd; dzOut = divByZero; hiAt = hi; loAt = lo;
                break;
            end
            @(posedge clk); #1;
            a = ~x; b = ~y;
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic runOp16(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                           output int doneCyc, output int stallCnt, output logic [31:0] fwd);
        start16 = 1'b1; op16 = o; a16 = x; b16 = y;
        doneCyc = -1; stallCnt = 0; fwd = '0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (stall16) stallCnt++;
            if (done16) begin
                doneCyc = c; fwd = hiloFwd16;
                break;
            end
            @(posedge clk); #1;
            a16 = ~x; b16 = ~y;
        end
        @(posedge clk); #1;
        start16 = 1'b0;
    endtask

    initial begin
        logic [31:0] fw16;
        rst = 1'b0; start = 1'b0; flush = 1'b0; op = 3'b000; a = '0; b = '0;
        start16 = 1'b0; flush16 = 1'b0; op16 = 3'b000; a16 = '0; b16 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hi", 64'(hi), 64'h0);
        check("rst_lo", 64'(lo), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_dbz", 64'(divByZero), 64'h0);
        check("rst_fwd", hiloFwd, 64'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        // MULT -2 * 3
        runOp(3'b000, 32'hFFFF_FFFE, 32'd3, dc, sc, fw, dz, hd, ld);
        check("mult_done_cyc", 64'(dc), 64'd3);
        check("mult_stall_cnt", 64'(sc), 64'd3);
        check("mult_fwd", fw, 64'hFFFF_FFFF_FFFF_FFFA);
        check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(lo), 64'hFFFF_FFFA);
        check("mult_busy_after", 64'(busy), 64'h0);

        // MULTU same operands
        runOp(3'b001, 32'hFFFF_FFFE, 32'd3, dc, sc, fw, dz, hd, ld);
        check("multu_done_cyc", 64'(dc), 64'd3);
        check("multu_hi", 64'(hi), 64'h2);
        check("multu_lo", 64'(lo), 64'hFFFF_FFFA);

        // DIV -7 / 2
        runOp(3'b010, 32'hFFFF_FFF9, 32'd2, dc, sc, fw, dz, hd, ld);
        check("div_done_cyc", 64'(dc), 64'd33);
        check("div_stall_cnt", 64'(sc), 64'd33);
        check("div_dbz", 64'(dz), 64'h0);
        check("div_lo", 64'(lo), 64'hFFFF_FFFD);
        check("div_hi", 64'(hi), 64'hFFFF_FFFF);

        // DIVU 7 / 2
        runOp(3'b011, 32'd7, 32'd2, dc, sc, fw, dz, hd, ld);
        check("divu_done_cyc", 64'(dc), 64'd33);
        check("divu_lo", 64'(lo), 64'd3);
        check("divu_hi", 64'(hi), 64'd1);

        // DIV by zero
        runOp(3'b010, 32'd5, 32'd0, dc, sc, fw, dz, hd, ld);
        check("dbz_done_cyc", 64'(dc), 64'd33);
        check("dbz_flag", 64'(dz), 64'h1);
        check("dbz_fwd", fw, 64'h0000_0005_FFFF_FFFF);
        check("dbz_hi", 64'(hi), 64'd5);
        check("dbz_lo", 64'(lo), 64'hFFFF_FFFF);

        // DIVU by zero
        runOp(3'b011, 32'h8000_0001, 32'd0, dc, sc, fw, dz, hd, ld);
        check("dbzu_flag", 64'(dz), 64'h1);
        check("dbzu_fwd", fw, 64'h8000_0001_FFFF_FFFF);

        // Most-negative / -1
        runOp(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, dc, sc, fw, dz, hd, ld);
        check("ovf_dbz", 64'(dz), 64'h0);
        check("ovf_lo", 64'(lo), 64'h8000_0000);
        check("ovf_hi", 64'(hi), 64'h0);

        // Flush in cycle 10 of DIVU, then MTHI next cycle
        start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(negedge clk);
        check("flush_done", 64'(done), 64'h0);
        check("flush_stall", 64'(stall), 64'h0);
        check("flush_fwd", hiloFwd, 64'h0000_0000_8000_0000);
        @(posedge clk); #1;
        flush = 1'b0; op = 3'b100; a = 32'h0000_ABCD; b = '0;
        check("flush_busy_next", 64'(busy), 64'h0);
        check("flush_hi_kept", 64'(hi), 64'h0);
        check("flush_lo_kept", 64'(lo), 64'h8000_0000);
        @(negedge clk);
        check("mthi_done", 64'(done), 64'h1);
        check("mthi_stall", 64'(stall), 64'h0);
        check("mthi_fwd", hiloFwd, 64'h0000_ABCD_8000_0000);
        @(posedge clk); #1;
        start = 1'b0;
        check("mthi_hi", 64'(hi), 64'h0000_ABCD);
        check("mthi_lo", 64'(lo), 64'h8000_0000);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("flush_no_done", 64'(cnt), 64'h0);
        @(posedge clk); #1;

        // Unsupported op: never busy, never done, no stall
        start = 1'b1; op = 3'b110; a = 32'h1; b = 32'h1;
        @(negedge clk);
        check("nop_done", 64'(done), 64'h0);
        check("nop_stall", 64'(stall), 64'h0);
        @(posedge clk); #1;
        check("nop_busy", 64'(busy), 64'h0);
        start = 1'b0;

        // Back-to-back MTHI 0, MTLO 0x55, MULT 2x3
        runOp(3'b100, 32'h0, 32'h0, dc, sc, fw, dz, hd, ld);
        check("b2b_mthi_cyc", 64'(dc), 64'd0);
        runOp(3'b101, 32'h55, 32'h0, dc, sc, fw, dz, hd, ld);
        check("b2b_mtlo_cyc", 64'(dc), 64'd0);
        check("b2b_mtlo_fwd", fw, 64'h0000_0000_0000_0055);
        runOp(3'b000, 32'd2, 32'd3, dc, sc, fw, dz, hd, ld);
        check("b2b_mult_cyc", 64'(dc), 64'd3);
        check("b2b_fwd", fw, 64'h0000_0000_0000_0006);
        check("b2b_hi_at_done", 64'(hd), 64'h0);
        check("b2b_lo_at_done", 64'(ld), 64'h55);
        check("b2b_lo", 64'(lo), 64'd6);
        check("b2b_hi", 64'(hi), 64'd0);

        // Asynchronous reset in cycle 10 of a DIV
        start = 1'b1; op = 3'b010; a = 32'd100; b = 32'd3;
        repeat (10) begin @(posedge clk); #1; end
        check("pre_rst_busy", 64'(busy), 64'h1);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'h0);
        check("arst_done", 64'(done), 64'h0);
        check("arst_hi", 64'(hi), 64'h0);
        check("arst_lo", 64'(lo), 64'h0);
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        runOp(3'b101, 32'h1234, 32'h0, dc, sc, fw, dz, hd, ld);
        check("post_rst_mtlo_cyc", 64'(dc), 64'd0);
        check("post_rst_lo", 64'(lo), 64'h0000_1234);
        check("post_rst_hi", 64'(hi), 64'h0);

        // 16-bit instance with single-cycle multiply
        runOp16(3'b000, 16'hFFFE, 16'd3, dc, sc, fw16);
        check("w16_mult_cyc", 64'(dc), 64'd1);
        check("w16_mult_stall", 64'(sc), 64'd1);
        check("w16_mult_fwd", 64'(fw16), 64'hFFFF_FFFA);
        check("w16_mult_hi", 64'(hi16), 64'hFFFF);
        check("w16_mult_lo", 64'(lo16), 64'hFFFA);
        runOp16(3'b001, 16'hFFFE, 16'd3, dc, sc, fw16);
        check("w16_multu_hi", 64'(hi16), 64'h2);
        check("w16_multu_lo", 64'(lo16), 64'hFFFA);
        runOp16(3'b010, 16'hFFF9, 16'd2, dc, sc, fw16);
        check("w16_div_cyc", 64'(dc), 64'd17);
        check("w16_div_lo", 64'(lo16), 64'hFFFD);
        check("w16_div_hi", 64'(hi16), 64'hFFFF);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
